popcount_rr_sched: RTL
======================

// Module: popcount_rr_sched
// PURPOSE
//  Shares one serial (1 bit/cycle) population-count engine among NREQ requesters.
//  Round-robin arbitration picks a requester, latches its word and counts ones over W cycles.
//  It returns the count tagged with the requester id on a valid/ready result port.
//  Sits between multiple client blocks and the single bit-serial counter datapath.
// PARAMETERS
//  NREQ  4   number of requesters (>=1)
//  W     16  data word width (>=1)
//  CW    localparam = clog2(W+1); count width, holds 0..W without wrap (5 for W=16)
//  IDW   localparam = max(1, clog2(NREQ)); requester id width
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  req_valid  in   NREQ    per-requester request; held until req_ready seen
//  req_data   in   NREQ*W  word of requester i at [i*W +: W]; stable while valid
//  req_ready  out  NREQ    one-hot grant/accept strobe, 1 cycle
//  res_valid  out  1       result available
//  res_ready  in   1       result consumer ready
//  res_count  out  CW      number of 1s in accepted word
//  res_id     out  IDW     index of requester that issued the word
//  busy       out  1       high in COUNT or RESP
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, res_valid=0, res_count=0, res_id=0, busy=0, rr_ptr=NREQ-1.
//  FSM IDLE -> COUNT -> RESP -> IDLE.
//  IDLE: if any req_valid, grant g = first valid index searching rr_ptr+1, rr_ptr+2, ... mod NREQ.
//   req_ready[g]=1 combinationally in that cycle (only in IDLE). The handshake completes there.
//   At the edge: shift_reg<=req_data[g], acc<=0, bit_idx<=0, id<=g, state<=COUNT.
//   No valid -> stay in IDLE with all req_ready=0.
//  COUNT: each cycle acc<=acc+shift_reg[0], shift_reg<=shift_reg>>1, bit_idx++.
//   When bit_idx==W-1, that addition is the final one and state<=RESP.
//   COUNT always lasts exactly W cycles. There is no early exit on zero data.
//  RESP: res_valid=1; res_count=acc, res_id=id, held stable until res_ready.
//   On res_valid&&res_ready: res_valid<=0, rr_ptr<=id, state<=IDLE.
//  Latency: accept edge at cycle t, res_valid high at cycle t+W+1.
//   Best-case throughput is one word per W+2 cycles (1 IDLE + W COUNT + 1 RESP).
//  Arithmetic: acc is CW bits. Max value W never overflows, so all-ones W=16 gives 16.
//  Simultaneous requests: only one grant per IDLE cycle. Losers keep valid asserted and wait.
//  Backpressure: while RESP and !res_ready, no new grant and all outputs frozen.
//  Reset mid-operation (COUNT or RESP): operation aborted and no result emitted.
//   All state returns to reset values. The in-flight requester is not re-served automatically.
//  NREQ=1: rr_ptr is a constant 0 and grant is always requester 0.
//  busy = (state != IDLE).
// STRUCTURE
//  Package popcount_pkg:
//   - clog2 function
//   - typedef enum {IDLE, COUNT, RESP} sched_state_t
//   - default W and NREQ constants
//  Sub-module popcount_serial_core(clk, reset, load, din[W], done, count[CW]).
//   It holds shift_reg, acc and bit_idx. load starts a run; done pulses on the last COUNT cycle.
//   The top level holds the arbiter (rr_ptr, grant mux), the FSM and the result registers.
// TESTING
//  1 req0 valid with 16'hFFFF, res_ready=1:
//    req_ready[0] at t; res_valid at t+17 with res_count=16, res_id=0.
//  2 req2 word 16'h0000 -> res_count=0, res_id=2. Then word 16'hA5A5 -> res_count=8.
//  3 all four valid continuously with distinct words, after reset:
//    grant order 0,1,2,3,0,...; each res_id matches its grant.
//  4 res_ready held low 5 cycles in RESP:
//    res_valid/res_count/res_id stable, req_ready all 0, busy=1. Released -> IDLE next cycle.
//  5 reset asserted on COUNT cycle 7 with req1,req3 pending:
//    next cycle res_valid=0, busy=0. First grant after release is req1 (from rr_ptr=3).
//  6 16'h8001 from req3 -> res_count=2 at exactly t+17. req_ready never asserted twice per request.

Source files
------------

// File: rtl/popcount_pkg.sv
// popcount_pkg: shared state type, default sizes and width helper for the popcount scheduler
package popcount_pkg;
    localparam int DEF_NREQ = 4;
    localparam int DEF_W = 16;
    typedef enum logic [1:0] {IDLE, COUNT, RESP} sched_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/popcount_serial_core.sv
// popcount_serial_core: bit-serial ones counter, one bit per cycle over a W-bit word
module popcount_serial_core
    import popcount_pkg::*;
#(
    parameter int W = DEF_W,
    localparam int CW = clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [W-1:0]  din_i,
    output logic          done_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  shift_q;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] idx_q;
    logic          run_q;
    assign done_o = run_q && idx_q == CW'(W - 1);
    assign count_o = acc_q;
    // Load a fresh word, then add its LSB and shift right once per cycle until the last bit is counted
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            acc_q <= '0;
            idx_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= din_i;
            acc_q <= '0;
            idx_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_q + CW'(shift_q[0]);
            shift_q <= shift_q >> 1;
            idx_q <= idx_q + 1'b1;
            run_q <= !done_o;
        end
    end
endmodule

// File: rtl/popcount_rr_sched.sv
// popcount_rr_sched: round-robin arbiter sharing one serial popcount engine among NREQ requesters
module popcount_rr_sched
    import popcount_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W = DEF_W,
    localparam int CW = clog2(W + 1),
    localparam int IDW = NREQ > 1 ? clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*W-1:0] req_data_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CW-1:0]     res_count_o,
    output logic [IDW-1:0]    res_id_o,
    output logic              busy_o
);
    sched_state_t   state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] gnt, cand;
    logic [W-1:0]   words [NREQ];
    logic           load, done;
    for (genvar i = 0; i < NREQ; i++) begin : g_word
        assign words[i] = req_data_i[i*W +: W];
    end
    // Walk candidates from farthest to nearest after rr_ptr so the nearest valid requester wins
    always_comb begin
        gnt = rr_ptr_q;
        cand = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid_i[cand]) gnt = cand;
        end
    end
    assign load = state_q == IDLE && |req_valid_i;
    assign req_ready_o = load ? NREQ'(1) << gnt : '0;
    assign res_valid_o = state_q == RESP;
    assign res_id_o = id_q;
    assign busy_o = state_q != IDLE;
    popcount_serial_core #(.W(W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .din_i   (words[gnt]),
        .done_o  (done),
        .count_o (res_count_o)
    );
    // Sequence accept -> count -> respond; pointer advances only once the result is taken
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d = id_q;
        unique case (state_q)
            IDLE: if (load) begin
                id_d = gnt;
                state_d = COUNT;
            end
            COUNT: if (done) state_d = RESP;
            RESP: if (res_ready_i) begin
                rr_ptr_d = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State, arbitration pointer and result id registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_ptr_q <= IDW'(NREQ - 1);
            id_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q <= id_d;
        end
    end
endmodule
